// File: rtl/gen_bus_arb_pkg.sv
// Shared types and helpers for the generic bus arbiter.
package gen_bus_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Requester numbering follows the coherency-unit CPUID scheme: two ports per hart.
    function automatic int ICACHE_REQ(input int h);
        return 2 * h;
    endfunction

    function automatic int DCACHE_REQ(input int h);
        return 2 * h + 1;
    endfunction

endpackage

// File: rtl/gen_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin find-first: first set request at or after i_ptr, with wraparound.
module rr_priority_picker
    import gen_bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [IDX_W-1:0] w_cand [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, i_ptr} + (IDX_W+1)'(gi);
            assign w_cand[gi] = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                                IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum[IDX_W-1:0];
            assign w_hit[gi] = i_req[w_cand[gi]];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_found = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/gen_bus_arbiter.sv
// Round-robin arbiter sharing one generic bus among NUM_REQ requesters, with bounded lock.
// Define GEN_BUS_ARB_PERF_EN to add per-requester grant/wait counters.
module gen_bus_arbiter
    import gen_bus_arb_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  ADDR_W   = 32,
    parameter int  DATA_W   = 32,
    parameter int  MAX_LOCK = 8,
    localparam int IDX_W    = idx_width(NUM_REQ),
    localparam int BE_W     = DATA_W / 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req_ren,
    input  logic [NUM_REQ-1:0]        req_wen,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*BE_W-1:0]   req_byte_en,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      bus_ren,
    output logic                      bus_wen,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic [BE_W-1:0]           bus_byte_en,
    input  logic [DATA_W-1:0]         bus_rdata,
    input  logic                      bus_busy,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      grant_valid
`ifdef GEN_BUS_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]     grant_count,
    output logic [NUM_REQ*32-1:0]     wait_count
`endif
);

    localparam int         BEAT_W  = idx_width(MAX_LOCK);
    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_ISSUE = ISSUE;

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_grant_idx;
    logic              r_grant_valid;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_beat_open;

    logic [ADDR_W-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] w_wdata_arr [NUM_REQ];
    logic [BE_W-1:0]   w_be_arr    [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign w_be_arr[gi]    = req_byte_en[gi*BE_W +: BE_W];
        end
    endgenerate

    logic [NUM_REQ-1:0] w_req;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;

    assign w_req = req_ren | req_wen;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    logic             w_issue;
    logic             w_g_ren;
    logic             w_g_wen;
    logic             w_g_act;
    logic             w_g_lock;
    logic             w_done;
    logic             w_lock_cont;
    logic             w_release;
    logic [IDX_W-1:0] w_rr_next;

    assign w_issue     = (r_state == S_ISSUE);
    assign w_g_ren     = req_ren[r_grant_idx];
    assign w_g_wen     = req_wen[r_grant_idx];
    assign w_g_act     = w_g_ren | w_g_wen;
    assign w_g_lock    = req_lock[r_grant_idx];
    assign w_done      = w_issue && w_g_act && !bus_busy;
    assign w_lock_cont = w_g_lock && (r_beat_cnt < BEAT_W'(MAX_LOCK - 1));
    // An idle locked owner keeps the bus; it lets go as soon as its lock drops.
    assign w_release   = w_issue && (w_done ? !w_lock_cont : (!w_g_act && !w_g_lock));
    assign w_rr_next   = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

    // Busy is forced high during reset so an abandoned beat never looks complete.
    always_comb begin
        bus_ren     = 1'b0;
        bus_wen     = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_byte_en = '0;
        req_busy    = '1;
        if (w_issue) begin
            bus_ren     = w_g_ren;
            bus_wen     = w_g_wen;
            bus_addr    = w_addr_arr[r_grant_idx];
            bus_wdata   = w_wdata_arr[r_grant_idx];
            bus_byte_en = w_be_arr[r_grant_idx];
            if (!RST) begin
                req_busy[r_grant_idx] = bus_busy;
            end
        end
    end

    assign req_rdata   = bus_rdata;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_beat_cnt    <= '0;
            r_beat_open   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                assert (!(req_ren[k] && req_wen[k]));
            end
            assert (!(r_beat_open && w_issue && !w_g_act));
            r_beat_open <= w_issue && w_g_act && bus_busy;

            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_grant_idx   <= w_pick_idx;
                        r_grant_valid <= 1'b1;
                        r_beat_cnt    <= '0;
                        r_state       <= S_ISSUE;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_state       <= S_IDLE;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= w_rr_next;
                    end else if (w_done) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef GEN_BUS_ARB_PERF_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
            logic [31:0] r_grant_cnt;
            logic [31:0] r_wait_cnt;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_grant_cnt <= '0;
                    r_wait_cnt  <= '0;
                end else begin
                    if (w_done && (r_grant_idx == IDX_W'(gi)) && (r_grant_cnt != '1)) begin
                        r_grant_cnt <= r_grant_cnt + 32'd1;
                    end
                    if (w_req[gi] && req_busy[gi] && (r_wait_cnt != '1)) begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
            end
            assign grant_count[gi*32 +: 32] = r_grant_cnt;
            assign wait_count[gi*32 +: 32]  = r_wait_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_gen_bus_arbiter.sv
// Directed bench for gen_bus_arbiter: vector table plus hand-written lock/reset/latency sequences.
// Perf-counter sequence is compiled in when GEN_BUS_ARB_PERF_EN is defined.
module tb_gen_bus_arbiter;
    import gen_bus_arb_pkg::*;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   req_ren = '0;
    logic [3:0]   req_wen = '0;
    logic [3:0]   req_lock = '0;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_byte_en;
    logic [3:0]   req_busy;
    logic [31:0]  req_rdata;
    logic         bus_ren;
    logic         bus_wen;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_byte_en;
    logic [31:0]  bus_rdata = '0;
    logic         bus_busy = 1'b0;
    logic [1:0]   grant_idx;
    logic         grant_valid;
`ifdef GEN_BUS_ARB_PERF_EN
    logic [127:0] grant_count;
    logic [127:0] wait_count;
`endif

    gen_bus_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_ren     (req_ren),
        .req_wen     (req_wen),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_byte_en (req_byte_en),
        .req_busy    (req_busy),
        .req_rdata   (req_rdata),
        .bus_ren     (bus_ren),
        .bus_wen     (bus_wen),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_byte_en (bus_byte_en),
        .bus_rdata   (bus_rdata),
        .bus_busy    (bus_busy),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
`ifdef GEN_BUS_ARB_PERF_EN
        ,
        .grant_count (grant_count),
        .wait_count  (wait_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      name;
        logic [3:0] ren;
        logic [3:0] wen;
        logic [3:0] lock;
        logic       busy;
        logic       gv;
        logic [1:0] gi;
        logic       bren;
        logic       bwen;
        logic [3:0] rbusy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [3:0] ren, input logic [3:0] wen,
                       input logic [3:0] lock, input logic busy, input logic gv,
                       input logic [1:0] gi, input logic bren, input logic bwen,
                       input logic [3:0] rbusy);
        vec_t v;
        v.name = n; v.ren = ren; v.wen = wen; v.lock = lock; v.busy = busy;
        v.gv = gv; v.gi = gi; v.bren = bren; v.bwen = bwen; v.rbusy = rbusy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; req_ren = '0; req_wen = '0; req_lock = '0; bus_busy = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    int beats0;
    int served1;

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]  = 32'h1000_0000 + 32'(i * 16);
            req_wdata[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
            req_byte_en[i*4 +: 4] = 4'hF;
        end

        // name, ren, wen, lock, busy | gv, gi, bus_ren, bus_wen, req_busy
        add("rr_idle0",   4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111);
        add("rr_g0",      4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1110);
        add("rr_idle1",   4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111);
        add("rr_g1",      4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1101);
        add("rr_idle2",   4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'b1111);
        add("rr_g2",      4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b1011);
        add("rr_idle3",   4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'b1111);
        add("rr_g3",      4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0111);
        add("rr_idle4",   4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 4'b1111);
        add("rr_wrap_g0", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1110);
        add("wr_idle",    4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111);
        add("wr_wait",    4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 4'b1111);
        add("wr_done",    4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'b1011);
        add("quiet",      4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'b1111);
        add("wrap_pick",  4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'b1111);
        add("lock_beat",  4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1110);
        add("lock_hold",  4'b0010, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b1110);
        add("lock_drop",  4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b1110);
        add("post_drop",  4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111);
        add("g1_after",   4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1101);
        add("end_idle",   4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'b1111);

        // Reset state
        do_reset();
        #2;
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_grant_idx", grant_idx, 2'd0);
        chk("rst_bus_ren", bus_ren, 1'b0);
        chk("rst_bus_wen", bus_wen, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_byte_en", bus_byte_en, 4'h0);
        chk("rst_req_busy", req_busy, 4'hF);
        chk("rst_rr_ptr", dut.r_rr_ptr, 2'd0);
        $display("reset: gv=%0b gi=%0d req_busy=%b", grant_valid, grant_idx, req_busy);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            req_ren  = vecs[i].ren;
            req_wen  = vecs[i].wen;
            req_lock = vecs[i].lock;
            bus_busy = vecs[i].busy;
            #2;
            chk(vecs[i].name, {grant_valid, grant_idx, bus_ren, bus_wen, req_busy},
                {vecs[i].gv, vecs[i].gi, vecs[i].bren, vecs[i].bwen, vecs[i].rbusy});
            if (vecs[i].bren || vecs[i].bwen)
                chk({vecs[i].name, "_addr"}, bus_addr, 32'h1000_0000 + 32'(vecs[i].gi) * 32'd16);
            if (vecs[i].bwen)
                chk({vecs[i].name, "_wdata"}, bus_wdata, 32'hA5A5_0000 + 32'(vecs[i].gi));
            $display("vec %0d %s: gv=%0b gi=%0d ren=%0b wen=%0b req_busy=%b",
                     i, vecs[i].name, grant_valid, grant_idx, bus_ren, bus_wen, req_busy);
            step();
        end

        // Single requester (I-cache of hart 1), two reads with 3 busy cycles each
        do_reset();
        for (int b = 0; b < 2; b++) begin
            req_addr[ICACHE_REQ(1)*32 +: 32] = 32'h8000_0000 + 32'(b * 4);
            req_ren = 4'b0100;
            for (int t = 0; t < 5; t++) begin
                bus_busy  = (t < 4);
                bus_rdata = 32'hC0DE_0000 + 32'(b * 16 + t);
                #2;
                chk($sformatf("rd%0d_t%0d_bus_ren", b, t), bus_ren, (t >= 1));
                chk($sformatf("rd%0d_t%0d_req_busy", b, t), req_busy,
                    (t == 4) ? 4'b1011 : 4'b1111);
                if (t >= 1)
                    chk($sformatf("rd%0d_t%0d_addr", b, t), bus_addr, 32'h8000_0000 + 32'(b * 4));
                if (t == 4)
                    chk($sformatf("rd%0d_rdata", b), req_rdata, 32'hC0DE_0000 + 32'(b * 16 + 4));
                step();
            end
            $display("read %0d by requester 2: addr=0x%08h rdata=0x%08h", b,
                     32'h8000_0000 + 32'(b * 4), req_rdata);
        end
        req_ren = '0;
        bus_busy = 1'b0;

        // Requester 1 locks for a 4-beat fill while requester 3 waits
        do_reset();
        req_ren  = 4'b1010;
        bus_busy = 1'b0;
        for (int t = 0; t < 7; t++) begin
            req_lock = (t < 4) ? 4'b0010 : 4'b0000;
            if (t == 5) req_ren = 4'b1000;
            #2;
            if (t >= 1 && t <= 4)
                chk($sformatf("lock_beat%0d", t), {grant_valid, grant_idx, bus_ren, req_busy},
                    {1'b1, 2'd1, 1'b1, 4'b1101});
            if (t == 5) begin
                chk("lock_rr_ptr", dut.r_rr_ptr, 2'd2);
                chk("lock_release_gv", grant_valid, 1'b0);
            end
            if (t == 6)
                chk("lock_next_owner", {grant_valid, grant_idx, req_busy}, {1'b1, 2'd3, 4'b0111});
            step();
        end
        req_ren = '0;
        req_lock = '0;
        $display("lock fill: requester 1 four beats, then requester 3");

        // Permanent lock by requester 0 is cut at MAX_LOCK beats
        do_reset();
        req_ren  = 4'b0011;
        req_lock = 4'b0001;
        bus_busy = 1'b0;
        beats0   = 0;
        served1  = 0;
        for (int t = 0; t < 40 && served1 == 0; t++) begin
            #2;
            if (grant_valid && bus_ren && grant_idx == 2'd0 && !req_busy[0]) beats0++;
            if (grant_valid && bus_ren && grant_idx == 2'd1 && !req_busy[1]) served1 = 1;
            step();
        end
        req_ren  = '0;
        req_lock = '0;
        chk("maxlock_beats", beats0, 8);
        chk("maxlock_r1_served", served1, 1);
        $display("max lock: requester 0 beats=%0d, requester 1 served=%0d", beats0, served1);

        // Reset in the middle of a busy beat
        do_reset();
        req_ren  = 4'b0001;
        bus_busy = 1'b0;
        #2; step();
        #2; step();
        req_ren  = 4'b0100;
        bus_busy = 1'b1;
        #2; step();
        #2;
        chk("rstmid_bus_ren", bus_ren, 1'b1);
        chk("rstmid_grant_idx", grant_idx, 2'd2);
        step();
        RST = 1'b1;
        #2;
        chk("rstmid_busy_in_rst", req_busy, 4'hF);
        step();
        RST = 1'b0;
        req_ren = '0;
        #2;
        chk("rstmid_after_bus_ren", bus_ren, 1'b0);
        chk("rstmid_after_gv", grant_valid, 1'b0);
        chk("rstmid_after_busy", req_busy, 4'hF);
        chk("rstmid_after_rr", dut.r_rr_ptr, 2'd0);
        chk("rstmid_after_gi", grant_idx, 2'd0);
        bus_busy = 1'b0;
        step();
        $display("reset mid-beat: gv=%0b bus_ren=%0b req_busy=%b", grant_valid, bus_ren, req_busy);

`ifdef GEN_BUS_ARB_PERF_EN
        // Five beats by requester 2, three cycles of waiting each
        do_reset();
        req_ren = 4'b0100;
        for (int b = 0; b < 5; b++) begin
            for (int t = 0; t < 4; t++) begin
                bus_busy = (t < 3);
                step();
            end
        end
        req_ren  = '0;
        bus_busy = 1'b0;
        #2;
        chk("perf_grant2", grant_count[64 +: 32], 32'd5);
        chk("perf_wait2", wait_count[64 +: 32], 32'd15);
        chk("perf_grant0", grant_count[0 +: 32], 32'd0);
        $display("perf: grant_count[2]=%0d wait_count[2]=%0d",
                 grant_count[64 +: 32], wait_count[64 +: 32]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
